// File: rtl/cache_lru_arbiter.sv
// Fill/access/update arbiter in front of a per-cache pseudo-LRU tracker.
// Optional feature: define LRU_ARB_ANTI_STARVE_EN to force periodic access bubbles.
module cache_lru_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_SETS     = 64,
  parameter int NUM_WAYS     = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int ID_W  = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       fill_req,
  input  logic [NUM_REQ*SET_W-1:0] fill_req_set,
  output logic [NUM_REQ-1:0]       fill_gnt,
  output logic                     fill_done,
  output logic [ID_W-1:0]          fill_done_id,
  output logic [WAY_W-1:0]         fill_done_way,
  input  logic                     access_req,
  input  logic [SET_W-1:0]         access_req_set,
  output logic                     access_gnt,
  input  logic                     update_req,
  input  logic [WAY_W-1:0]         update_req_way,
  output logic                     protocol_err,
  output logic                     lru_fill_en,
  output logic [SET_W-1:0]         lru_fill_set,
  input  logic [WAY_W-1:0]         lru_fill_way,
  output logic                     lru_access_en,
  output logic [SET_W-1:0]         lru_access_set,
  output logic                     lru_update_en,
  output logic [WAY_W-1:0]         lru_update_way
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic            win_valid;
  logic            bubble;
  logic            was_access;

  // Round-robin search: walking offsets high to low leaves the nearest
  // requester at or after rr_ptr as the winner.
  always_comb begin
    int idx;
    win_valid = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (fill_req[idx]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

`ifdef LRU_ARB_ANTI_STARVE_EN
  logic [7:0] starve_cnt;

  assign bubble = access_req && (starve_cnt == 8'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!access_req || access_gnt) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign bubble = 1'b0;
`endif

  // NOTE: the combinational grants are masked by reset so nothing reaches the
  // LRU or a requester while the arbiter state is being cleared.
  always_comb begin
    lru_fill_en    = win_valid && !bubble && !reset;
    fill_gnt       = '0;
    if (lru_fill_en) fill_gnt[win_id] = 1'b1;
    lru_fill_set   = fill_req_set[win_id*SET_W +: SET_W];
    access_gnt     = access_req && !lru_fill_en && !reset;
    lru_access_en  = access_gnt;
    lru_access_set = access_req_set;
    lru_update_en  = update_req && was_access && !reset;
    lru_update_way = update_req_way;
    fill_done_way  = fill_done ? lru_fill_way : '0;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      was_access   <= 1'b0;
      protocol_err <= 1'b0;
      fill_done    <= 1'b0;
      fill_done_id <= '0;
    end else begin
      if (lru_fill_en) begin
        rr_ptr       <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        fill_done_id <= win_id;
      end
      was_access <= access_gnt;
      fill_done  <= lru_fill_en;
      if (update_req && !was_access) protocol_err <= 1'b1;
    end
  end

endmodule

// File: doc/cache_lru_arbiter.md
# cache_lru_arbiter

Arbitrates the single fill port and the single access/update port of the per-cache pseudo-LRU tracker among several fill requesters and one hit-path client. Fills are granted round-robin and always win over accesses. Access/update ordering is enforced so the LRU never sees an update without a matching access one cycle earlier. It sits between the cache miss handlers and the LRU instance, and returns the victim way to the granted requester one cycle after grant.

## Interface
- NUM_REQ, 4: number of fill requesters, 2..8.
- NUM_SETS, 64: sets in the cache; SET_W = $clog2(NUM_SETS), minimum 1.
- NUM_WAYS, 4: ways per set (1, 2, 4, 8); WAY_W = $clog2(NUM_WAYS), minimum 1.
- STARVE_LIMIT, 8: consecutive stalled access cycles before a fill bubble is forced, 1..255.

- clk  in  1  clock, single domain.
- reset  in  1  synchronous, active-high.
- fill_req  in  NUM_REQ  per-requester fill request; held until granted.
- fill_req_set  in  NUM_REQ*SET_W  packed set index; requester i at [i*SET_W +: SET_W].
- fill_gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as request.
- fill_done  out  1  registered; victim way valid this cycle.
- fill_done_id  out  $clog2(NUM_REQ)  requester that owns fill_done.
- fill_done_way  out  WAY_W  victim way, equal to lru_fill_way while fill_done.
- access_req  in  1  hit-path lookup request.
- access_req_set  in  SET_W  set of the lookup.
- access_gnt  out  1  combinational; the lookup is issued to the LRU this cycle.
- update_req  in  1  hit indication, one cycle after access_gnt.
- update_req_way  in  WAY_W  hit way.
- protocol_err  out  1  sticky; an update_req arrived without access_gnt the previous cycle.
- lru_fill_en / lru_fill_set  out  1 / SET_W  to the LRU fill interface.
- lru_fill_way  in  WAY_W  from the LRU; valid one cycle after lru_fill_en.
- lru_access_en / lru_access_set  out  1 / SET_W  to the LRU access interface.
- lru_update_en / lru_update_way  out  1 / WAY_W  to the LRU update interface.

## Operation
- Fill arbitration:
  - Round-robin over fill_req, starting at rr_ptr.
  - When a winner exists and no bubble is forced: fill_gnt[w]=1, lru_fill_en=1, lru_fill_set = set of w.
  - On a grant, rr_ptr <= (w+1) mod NUM_REQ. rr_ptr does not change on idle cycles.
- Access gating: access_gnt = access_req && !lru_fill_en. lru_access_en = access_gnt. lru_access_set = access_req_set.
- Update path:
  - was_access <= access_gnt.
  - lru_update_en = update_req && was_access; lru_update_way = update_req_way.
  - update_req with was_access=0 is dropped and sets protocol_err. protocol_err clears only on reset.
- Response:
  - fill_done <= lru_fill_en; done_id <= w.
  - fill_done_way is lru_fill_way gated by fill_done (0 otherwise).
- A fill at cycle t followed by an update at t+1 cannot collide. An access is never granted in a cycle with a fill, so was_fill and lru_update_en are never both high.
- Same set filled on back-to-back cycles: legal. The LRU read-during-write returns new data, so the two fills receive distinct ways when NUM_WAYS>1.

## Timing
- Reset values: fill_gnt=0, fill_done=0, fill_done_id=0, fill_done_way=0, access_gnt=0, lru_*_en=0, protocol_err=0, rr_ptr=0, was_access=0, starve_cnt=0.
- Grant latency is 0 cycles. Victim latency is 1 cycle (fill_done at t+1 for a grant at t). Throughput is one fill per cycle.
- Reset asserted in cycle t+1 after a grant at t: fill_done is 0 in the cycle after reset, and no response is delivered. The requester must re-request.
- update_req in the same cycle as reset is ignored and does not set protocol_err.

## Configuration
- LRU_ARB_ANTI_STARVE_EN defined:
  - starve_cnt counts cycles with access_req && !access_gnt. It clears when access_gnt is high or access_req is low.
  - When starve_cnt == STARVE_LIMIT, fill grants are suppressed for that cycle, access_gnt=1, and starve_cnt clears.
  - rr_ptr holds during the suppressed cycle.
- Undefined: fills have strict priority, and access can be starved indefinitely. starve_cnt is not built.

## Test plan
- Reset, then fill_req=4'b1111 held for 4 cycles -> fill_gnt sequence 0001, 0010, 0100, 1000. fill_done_id = 0,1,2,3 on the following cycles.
- Fill requester 2 set 5 at t, with the LRU returning way 3 -> fill_done=1, fill_done_id=2, fill_done_way=3 at t+1. lru_fill_set=5 at t.
- access_req set 9 with no fills at t; update_req way 1 at t+1 -> lru_access_en at t, lru_update_en with way 1 at t+1, protocol_err=0.
- update_req with no preceding access_gnt -> lru_update_en=0, protocol_err=1, and it stays 1 until reset.
- LRU_ARB_ANTI_STARVE_EN defined, STARVE_LIMIT=8, fill_req continuously 1 and access_req continuously 1 -> access_gnt=1 exactly once every 9 cycles, with no fill_gnt in that cycle. Undefined: access_gnt stays 0 for 50 cycles.
- Grant at t with reset at t+1 -> fill_done=0 at t+2. rr_ptr=0, and the first grant after reset goes to the lowest requesting index.
